// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
// Bus widths match the APB master this arbiter feeds.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Round-robin picker: rotate requests past the pointer, take the lowest
// set bit, rotate the result back to an absolute one-hot grant and index.
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  start;
    logic [IW-1:0]  pos;
    logic [IW:0]    sum;
    logic           hit;

    // search starts one past the last owner, wrapping at N
    always_comb begin
        start = (ptr == IW'(N - 1)) ? '0 : ptr + 1'b1;
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        pos   = '0;
        hit   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = IW'(k);
                hit = 1'b1;
            end
        end
        sum = {1'b0, start} + {1'b0, pos};
        if (sum >= (IW + 1)'(N)) begin
            idx = IW'(sum - (IW + 1)'(N));
        end else begin
            idx = sum[IW-1:0];
        end
        grant = hit ? ({{(N - 1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master among several requesters with round-robin
// arbitration, a command latch, a completion monitor and a watchdog.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      transfer,
    output logic                      write,
    output logic [ADDR_W-1:0]         apb_write_paddr,
    output logic [ADDR_W-1:0]         apb_read_paddr,
    output logic [DATA_W-1:0]         apb_write_data,
    input  logic                      penable,
    input  logic                      pready,
    input  logic                      pslverr,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = idx_w(TIMEOUT_CYC);

    state_t              state;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       pick_idx;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [CW-1:0]       wd_cnt;
    logic                cpl;
    logic                expire;
    logic                busy;

    // pready alone is not a completion; only the enable phase counts
    assign cpl    = penable & pready;
    assign busy   = (state == BUSY);
    assign expire = (wd_cnt == CW'(TIMEOUT_CYC - 1));

    apb_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_gnt),
        .idx   (pick_idx)
    );

    // arbitration FSM, command latch and BUSY-cycle watchdog
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= IW'(NUM_REQ - 1);
            gnt       <= '0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            wd_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= pick_idx;
                        gnt       <= pick_gnt;
                        cmd_write <= req_write[pick_idx];
                        cmd_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        cmd_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        wd_cnt    <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cpl || expire) begin
                        state <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    gnt    <= '0;
                    rr_ptr <= owner;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // response capture; a completion in the expiry cycle still wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (busy && cpl) begin
            if (!cmd_write) begin
                rsp_rdata <= prdata;
            end
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
        end else if (busy && expire) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

    assign transfer        = busy;
    assign write           = busy & cmd_write;
    assign apb_write_paddr = (busy && cmd_write) ? cmd_addr : '0;
    assign apb_read_paddr  = (busy && !cmd_write) ? cmd_addr : '0;
    assign apb_write_data  = busy ? cmd_wdata : '0;
    assign done            = (state == DONE) ? gnt : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus a
// randomized phase checked against a round-robin reference model.
module tb_apb_req_arbiter;

    localparam int N = 4;
    localparam int T = 8;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_write = '0;
    logic [N*8-1:0] req_addr = '0;
    logic [N*8-1:0] req_wdata = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [7:0]     rsp_rdata;
    logic           rsp_err;
    logic           rsp_timeout;
    logic           transfer;
    logic           write;
    logic [7:0]     apb_write_paddr;
    logic [7:0]     apb_read_paddr;
    logic [7:0]     apb_write_data;
    logic           penable = 1'b0;
    logic           pready = 1'b0;
    logic           pslverr = 1'b0;
    logic [7:0]     prdata = '0;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int last_win = N - 1;
    logic [7:0] rd_model = '0;
    int ws_tab [0:6] = '{0, 1, 2, 3, 6, 7, 12};

    // results of the most recent served transfer
    int         s_kdone;
    int         s_done_cyc;
    logic [N-1:0] s_gnt, s_done;
    logic       s_write, s_err, s_to, s_stable, s_post, s_dx;
    logic [7:0] s_wpa, s_rpa, s_wd, s_rd;

    apb_req_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (8),
        .DATA_W      (8),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .req             (req),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .gnt             (gnt),
        .done            (done),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .rsp_timeout     (rsp_timeout),
        .transfer        (transfer),
        .write           (write),
        .apb_write_paddr (apb_write_paddr),
        .apb_read_paddr  (apb_read_paddr),
        .apb_write_data  (apb_write_data),
        .penable         (penable),
        .pready          (pready),
        .pslverr         (pslverr),
        .prdata          (prdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    // slave/monitor side of one transfer; ws = wait states before pready,
    // spur = pready asserted without penable while waiting
    task automatic serve(input int ws, input logic err, input logic [7:0] rd,
                         input bit spur, input bit drop);
        int n;
        n = 0;
        s_kdone = -1;
        s_stable = 1'b1;
        s_post = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!transfer && n < 20);
        if (!transfer) return;
        s_gnt = gnt;
        s_write = write;
        s_wpa = apb_write_paddr;
        s_rpa = apb_read_paddr;
        s_wd = apb_write_data;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (done != '0) begin
                    s_kdone = k;
                    s_done = done;
                    s_err = rsp_err;
                    s_to = rsp_timeout;
                    s_rd = rsp_rdata;
                    s_dx = transfer;
                    s_done_cyc = cyc;
                    break;
                end
                if (!transfer || gnt !== s_gnt || write !== s_write ||
                    apb_write_paddr !== s_wpa || apb_read_paddr !== s_rpa ||
                    apb_write_data !== s_wd) s_stable = 1'b0;
            end
            if (drop && k == 1) req = req & ~s_gnt;
            penable = (k >= 1 + ws) ? 1'b1 : (spur ? 1'b0 : (k >= 1));
            pready  = (k == 1 + ws) || (spur && k < 1 + ws);
            pslverr = (k == 1 + ws) ? err : 1'($urandom_range(0, 1));
            prdata  = (k == 1 + ws) ? rd : 8'($urandom);
        end
        penable = 1'b0;
        pready = 1'b0;
        @(negedge clk);
        s_post = (done == '0) && (gnt == '0) && !transfer;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({gnt, done, transfer, write, apb_write_paddr, apb_read_paddr,
             apb_write_data, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            $display("FAIL reset_outputs got gnt=%b done=%b xfer=%b rd=%h err=%b want all 0",
                     gnt, done, transfer, rsp_rdata, rsp_err);
        end else passed++;
        resetn = 1'b1;
    endtask

    task automatic test_rr_order;
        int order [0:4] = '{0, 1, 2, 3, 0};
        int prev;
        logic [N-1:0] eg;
        prev = -100;
        req_write = '0;
        req_addr = 32'h40302010;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(0, 1'b0, 8'(8'h60 + i), 0, 0);
            eg = N'(1) << order[i];
            total++;
            if (s_gnt !== eg || s_done !== eg || s_kdone != 2) begin
                $display("FAIL rr_order[%0d] got gnt=%b done=%b k=%0d want %b k=2",
                         i, s_gnt, s_done, s_kdone, eg);
            end else passed++;
            total++;
            if (s_done_cyc - prev < 3 || !s_post) begin
                $display("FAIL rr_gap[%0d] got gap=%0d post=%b want >=3 and 1",
                         i, s_done_cyc - prev, s_post);
            end else passed++;
            prev = s_done_cyc;
            rd_model = 8'(8'h60 + i);
        end
        last_win = 0;
        req = '0;
    endtask

    task automatic test_single_read;
        req_write[2] = 1'b0;
        req_addr[2*8 +: 8] = 8'h3C;
        req = 4'b0100;
        serve(2, 1'b0, 8'hA5, 0, 0);
        total++;
        if ({s_gnt, s_rpa, s_wpa, s_write} !== {4'b0100, 8'h3C, 8'h00, 1'b0}) begin
            $display("FAIL single_cmd got gnt=%b rpa=%h wpa=%h w=%b want 0100 3c 00 0",
                     s_gnt, s_rpa, s_wpa, s_write);
        end else passed++;
        rd_model = 8'hA5;
        total++;
        if ({s_done, s_rd, s_err, s_to, s_dx} !== {4'b0100, 8'hA5, 3'b000} ||
            s_kdone != 4 || !s_post || !s_stable) begin
            $display("FAIL single_rsp got done=%b rd=%h err=%b k=%0d post=%b want 0100 a5 0 4 1",
                     s_done, s_rd, s_err, s_kdone, s_post);
        end else passed++;
        last_win = 2;
        req = '0;
    endtask

    task automatic test_write_err;
        req_write[1] = 1'b1;
        req_addr[1*8 +: 8] = 8'h10;
        req_wdata[1*8 +: 8] = 8'h5A;
        req = 4'b0010;
        serve(1, 1'b1, 8'hFF, 0, 0);
        total++;
        if ({s_gnt, s_write, s_wpa, s_rpa, s_wd} !== {4'b0010, 1'b1, 8'h10, 8'h00, 8'h5A}) begin
            $display("FAIL write_cmd got gnt=%b w=%b wpa=%h rpa=%h wd=%h want 0010 1 10 00 5a",
                     s_gnt, s_write, s_wpa, s_rpa, s_wd);
        end else passed++;
        total++;
        if ({s_done, s_err, s_to, s_rd} !== {4'b0010, 1'b1, 1'b0, rd_model} || s_kdone != 3) begin
            $display("FAIL write_err got done=%b err=%b to=%b rd=%h k=%0d want 0010 1 0 %h 3",
                     s_done, s_err, s_to, s_rd, s_kdone, rd_model);
        end else passed++;
        last_win = 1;
        req = '0;
    endtask

    task automatic test_timeout;
        req_write = '0;
        req_addr[3*8 +: 8] = 8'h77;
        req_addr[0*8 +: 8] = 8'h20;
        req = 4'b1001;
        serve(12, 1'b0, 8'h99, 0, 0);
        total++;
        if ({s_gnt, s_done, s_err, s_to, s_rd} !== {4'b1000, 4'b1000, 2'b11, rd_model} ||
            s_kdone != T || !s_stable) begin
            $display("FAIL timeout got done=%b err=%b to=%b rd=%h k=%0d want 1000 1 1 %h %0d",
                     s_done, s_err, s_to, s_rd, s_kdone, rd_model, T);
        end else passed++;
        req[3] = 1'b0;
        serve(0, 1'b0, 8'h11, 0, 0);
        rd_model = 8'h11;
        total++;
        if ({s_gnt, s_rpa, s_err, s_to, s_rd} !== {4'b0001, 8'h20, 2'b00, 8'h11}) begin
            $display("FAIL after_timeout got gnt=%b rpa=%h err=%b to=%b rd=%h want 0001 20 0 0 11",
                     s_gnt, s_rpa, s_err, s_to, s_rd);
        end else passed++;
        last_win = 0;
        req = '0;
    endtask

    task automatic test_spurious_ready;
        req_write[2] = 1'b0;
        req_addr[2*8 +: 8] = 8'h44;
        req = 4'b0100;
        serve(3, 1'b0, 8'hC3, 1, 0);
        rd_model = 8'hC3;
        total++;
        if (s_kdone != 5 || !s_stable || {s_done, s_rd, s_err} !== {4'b0100, 8'hC3, 1'b0}) begin
            $display("FAIL spurious_ready got k=%0d stable=%b done=%b rd=%h want 5 1 0100 c3",
                     s_kdone, s_stable, s_done, s_rd);
        end else passed++;
        last_win = 2;
        req = '0;
    endtask

    task automatic test_reset_mid_busy;
        int n;
        req_write[2] = 1'b1;
        req = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!transfer && n < 20);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        total++;
        if (gnt !== '0 || transfer !== 1'b0 || done !== '0 || rsp_rdata !== '0 || n >= 20) begin
            $display("FAIL reset_mid_busy got gnt=%b xfer=%b done=%b rd=%h waits=%0d want 0",
                     gnt, transfer, done, rsp_rdata, n);
        end else passed++;
        rd_model = '0;
        last_win = N - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        req_write = '0;
        req = 4'b1111;
        serve(0, 1'b0, 8'h3E, 0, 0);
        total++;
        if (s_gnt !== 4'b0001 || s_kdone != 2) begin
            $display("FAIL reset_rr_restart got gnt=%b k=%0d want 0001 2", s_gnt, s_kdone);
        end else passed++;
        rd_model = 8'h3E;
        last_win = 0;
        req[0] = 1'b0;
    endtask

    task automatic test_random;
        int ex, ws;
        logic w, err, to;
        logic [7:0] a, d, rd;
        logic [N-1:0] eg;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req_write[i] = 1'($urandom_range(0, 1));
                    req_addr[i*8 +: 8] = 8'($urandom);
                    req_wdata[i*8 +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end
            end
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            ex = rr_next(req, last_win);
            eg = N'(1) << ex;
            w = req_write[ex];
            a = req_addr[ex*8 +: 8];
            d = req_wdata[ex*8 +: 8];
            ws = ws_tab[$urandom_range(0, 6)];
            err = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            to = (ws >= T - 1);
            serve(ws, err, rd, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            total++;
            if (s_gnt !== eg || s_done !== eg || s_kdone != (to ? T : ws + 2)) begin
                $display("FAIL rand_grant[%0d] got gnt=%b done=%b k=%0d want %b k=%0d",
                         it, s_gnt, s_done, s_kdone, eg, to ? T : ws + 2);
            end else passed++;
            total++;
            if ({s_write, s_wpa, s_rpa} !== {w, w ? a : 8'h00, w ? 8'h00 : a} ||
                (w && s_wd !== d)) begin
                $display("FAIL rand_cmd[%0d] got w=%b wpa=%h rpa=%h wd=%h want w=%b a=%h d=%h",
                         it, s_write, s_wpa, s_rpa, s_wd, w, a, d);
            end else passed++;
            if (!to && !w) rd_model = rd;
            total++;
            if ({s_err, s_to, s_rd} !== {to ? 1'b1 : err, to, rd_model}) begin
                $display("FAIL rand_rsp[%0d] got err=%b to=%b rd=%h want %b %b %h",
                         it, s_err, s_to, s_rd, to ? 1'b1 : err, to, rd_model);
            end else passed++;
            total++;
            if (!s_stable || !s_post || s_dx !== 1'b0) begin
                $display("FAIL rand_hold[%0d] got stable=%b post=%b xfer_in_done=%b want 1 1 0",
                         it, s_stable, s_post, s_dx);
            end else passed++;
            last_win = ex;
            req[ex] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_single_read();
        test_write_err();
        test_timeout();
        test_spurious_ready();
        test_reset_mid_busy();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
